// File: rtl/uart_rx_fsmd_if.sv
// Host/line-side bundle for the UART receiver: serial input, read strobe, holding-register outputs.
interface uart_rx_if #(
  parameter int unsigned DATA_SIZE = 8
);
  logic                 rx_in;
  logic                 rx_read;
  logic [DATA_SIZE-1:0] rx_data;
  logic                 rx_valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun_err;
  logic                 busy;

  modport master (
    output rx_in, rx_read,
    input  rx_data, rx_valid, parity_err, frame_err, overrun_err, busy
  );

  modport slave (
    input  rx_in, rx_read,
    output rx_data, rx_valid, parity_err, frame_err, overrun_err, busy
  );
endinterface

// File: rtl/uart_rx_fsmd.sv
// UART receiver: 2-flop sync, mid-bit sampling, LSB-first reassembly, even parity / stop check,
// and a single-entry holding register with valid/read handshake and sticky overrun.
module uart_rx_fsmd #(
  parameter int unsigned PARITY_ON           = 1,
  parameter int unsigned DATA_SIZE           = 8,
  parameter int unsigned SAMPLING_CNTR_WIDTH = 4,
  parameter int unsigned NO_OF_CLKS          = 16
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave rx_if
);

  localparam int unsigned CW = SAMPLING_CNTR_WIDTH;
  localparam logic [CW-1:0] HALF_TERM = CW'(NO_OF_CLKS / 2 - 1);
  localparam logic [CW-1:0] FULL_TERM = CW'(NO_OF_CLKS - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e               state_q;
  logic                 rx_meta_q;
  logic                 rx_s_q;
  logic [CW-1:0]        sample_cnt_q;
  logic [2:0]           bit_cnt_q;
  logic [DATA_SIZE-1:0] shift_q;
  logic                 p_err_q;
  logic                 busy_q;

  logic [DATA_SIZE-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 parity_err_q;
  logic                 frame_err_q;
  logic                 overrun_err_q;

  logic half_done;
  logic full_done;
  logic commit;

  assign half_done = (sample_cnt_q == HALF_TERM);
  assign full_done = (sample_cnt_q == FULL_TERM);
  assign commit    = (state_q == STOP) && full_done;

  // Two-flop synchroniser; the line idles high so reset to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_if.rx_in;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Frame FSM with its datapath; counters restart on every state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sample_cnt_q <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      p_err_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            state_q      <= START;
            busy_q       <= 1'b1;
            sample_cnt_q <= '0;
            bit_cnt_q    <= '0;
          end
        end
        START: begin
          if (half_done) begin
            sample_cnt_q <= '0;
            bit_cnt_q    <= '0;
            if (!rx_s_q) begin
              state_q <= DATA;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            sample_cnt_q <= sample_cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (full_done) begin
            sample_cnt_q <= '0;
            shift_q      <= {rx_s_q, shift_q[DATA_SIZE-1:1]};
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_q <= '0;
              state_q   <= (PARITY_ON != 0) ? PARITY : STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end else begin
            sample_cnt_q <= sample_cnt_q + 1'b1;
          end
        end
        PARITY: begin
          if (full_done) begin
            sample_cnt_q <= '0;
            bit_cnt_q    <= '0;
            p_err_q      <= rx_s_q ^ (^shift_q);
            state_q      <= STOP;
          end else begin
            sample_cnt_q <= sample_cnt_q + 1'b1;
          end
        end
        STOP: begin
          // Remaining half stop bit is absorbed in IDLE so back-to-back frames work.
          if (full_done) begin
            sample_cnt_q <= '0;
            bit_cnt_q    <= '0;
            state_q      <= IDLE;
            busy_q       <= 1'b0;
          end else begin
            sample_cnt_q <= sample_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q      <= IDLE;
          busy_q       <= 1'b0;
          sample_cnt_q <= '0;
          bit_cnt_q    <= '0;
        end
      endcase
    end
  end

  // Holding register: a read in the commit cycle frees the slot for the new frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      parity_err_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else if (commit) begin
      if (!rx_valid_q || rx_if.rx_read) begin
        rx_data_q    <= shift_q;
        parity_err_q <= p_err_q;
        frame_err_q  <= ~rx_s_q;
        rx_valid_q   <= 1'b1;
        if (rx_if.rx_read) begin
          overrun_err_q <= 1'b0;
        end
      end else begin
        overrun_err_q <= 1'b1;
      end
    end else if (rx_if.rx_read) begin
      rx_valid_q    <= 1'b0;
      parity_err_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end
  end

  assign rx_if.rx_data     = rx_data_q;
  assign rx_if.rx_valid    = rx_valid_q;
  assign rx_if.parity_err  = parity_err_q;
  assign rx_if.frame_err   = frame_err_q;
  assign rx_if.overrun_err = overrun_err_q;
  assign rx_if.busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_fsmd.sv
// Bench for uart_rx_fsmd: directed and randomized frames on a default-parameter receiver and a
// 7-bit/no-parity receiver, checked against a frame-level model of the holding register.
module tb_uart_rx_fsmd;

  localparam int NCLK = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_rx_if #(.DATA_SIZE(8)) ia ();
  uart_rx_if #(.DATA_SIZE(7)) ib ();

  uart_rx_fsmd #(
    .PARITY_ON(1), .DATA_SIZE(8), .SAMPLING_CNTR_WIDTH(4), .NO_OF_CLKS(16)
  ) dut_a (
    .clk   (clk),
    .rst   (rst),
    .rx_if (ia)
  );

  uart_rx_fsmd #(
    .PARITY_ON(0), .DATA_SIZE(7), .SAMPLING_CNTR_WIDTH(4), .NO_OF_CLKS(16)
  ) dut_b (
    .clk   (clk),
    .rst   (rst),
    .rx_if (ib)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Frame-level model of the default receiver's host-visible state.
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_perr;
  logic       m_ferr;
  logic       m_ovr;

  int          rise_edge;
  bit          busy_seen;
  logic [12:0] rst_snap;

  function automatic logic [12:0] act_vec();
    return {ia.rx_valid, ia.rx_data, ia.parity_err, ia.frame_err, ia.overrun_err, ia.busy};
  endfunction

  function automatic logic [12:0] exp_vec();
    return {m_valid, m_data, m_perr, m_ferr, m_ovr, 1'b0};
  endfunction

  function automatic int commit_cyc(input int nb, input int par_on);
    return 2 + NCLK / 2 + NCLK * (nb + par_on + 1);
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_data = '0; m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
  endtask

  // One host-visible event: a completed frame, a read, or both in the same cycle.
  task automatic model_event(input bit frame, input logic [7:0] d, input bit pe, input bit fe,
                             input bit rd);
    if (frame) begin
      if (!m_valid || rd) begin
        m_data = d; m_perr = pe; m_ferr = fe; m_valid = 1'b1;
        if (rd) m_ovr = 1'b0;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (rd) begin
      m_valid = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    end
  endtask

  // Drives one frame bit-by-bit from posedge+1; cycle index cyc is sampled by edge cyc.
  task automatic send_frame(input bit on_b, input logic [7:0] d, input int nb, input int par_on,
                            input logic par_bit, input logic stop_bit, input int gap,
                            input int read_cyc, input int rst_cyc);
    int   total;
    int   b;
    logic v;
    logic v_prev;
    logic v_now;
    total     = NCLK * (2 + nb + par_on) + gap;
    rise_edge = -1;
    busy_seen = 1'b0;
    v_prev    = on_b ? ib.rx_valid : ia.rx_valid;
    for (int cyc = 0; cyc < total; cyc++) begin
      b = cyc / NCLK;
      if (b == 0)                             v = 1'b0;
      else if (b <= nb)                       v = d[b-1];
      else if (par_on != 0 && b == nb + 1)    v = par_bit;
      else if (b == nb + 1 + par_on)          v = stop_bit;
      else                                    v = 1'b1;
      if (on_b) begin
        ib.rx_in = v; ib.rx_read = (cyc == read_cyc);
      end else begin
        ia.rx_in = v; ia.rx_read = (cyc == read_cyc);
      end
      if (cyc == rst_cyc) begin
        #2 rst = 1'b1;
        #1 rst_snap = act_vec();
        ia.rx_in = 1'b1; ib.rx_in = 1'b1; ia.rx_read = 1'b0; ib.rx_read = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        return;
      end
      @(posedge clk); #1;
      v_now = on_b ? ib.rx_valid : ia.rx_valid;
      if (!v_prev && v_now && rise_edge < 0) rise_edge = cyc;
      v_prev = v_now;
      busy_seen |= (on_b ? ib.busy : ia.busy);
    end
    ia.rx_in = 1'b1; ib.rx_in = 1'b1; ia.rx_read = 1'b0; ib.rx_read = 1'b0;
  endtask

  task automatic do_read(input bit on_b);
    if (on_b) ib.rx_read = 1'b1; else ia.rx_read = 1'b1;
    @(posedge clk); #1;
    ia.rx_read = 1'b0; ib.rx_read = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ia.rx_in = 1'b1; ia.rx_read = 1'b0;
    ib.rx_in = 1'b1; ib.rx_read = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (act_vec() !== 13'h0) begin
      n_err++; $display("FAIL reset_a_in_reset: got %h want %h", act_vec(), 13'h0);
    end
    n_cmp++;
    if ({ib.rx_valid, ib.rx_data, ib.parity_err, ib.frame_err, ib.overrun_err, ib.busy} !== 12'h0) begin
      n_err++; $display("FAIL reset_b_in_reset: got %h want 000",
                        {ib.rx_valid, ib.rx_data, ib.parity_err, ib.frame_err, ib.overrun_err, ib.busy});
    end
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (act_vec() !== exp_vec()) begin
      n_err++; $display("FAIL reset_a_idle: got %h want %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_basic();
    send_frame(1'b0, 8'hA5, 8, 1, 1'b0, 1'b1, 0, -1, -1);
    model_event(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (rise_edge != commit_cyc(8, 1)) begin
      n_err++; $display("FAIL basic_latency: got edge %0d want %0d", rise_edge, commit_cyc(8, 1));
    end
    n_cmp++;
    if (act_vec() !== exp_vec()) begin
      n_err++; $display("FAIL basic_a5: got %h want %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_parity();
    do_read(1'b0);
    model_event(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (act_vec() !== exp_vec()) begin
      n_err++; $display("FAIL parity_read_clear: got %h want %h", act_vec(), exp_vec());
    end
    send_frame(1'b0, 8'h3C, 8, 1, 1'b1, 1'b1, 0, -1, -1);
    model_event(1'b1, 8'h3C, 1'b1 != (^8'h3C), 1'b0, 1'b0);
    n_cmp++;
    if (act_vec() !== exp_vec()) begin
      n_err++; $display("FAIL parity_3c: got %h want %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_frame_err();
    do_read(1'b0);
    model_event(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    send_frame(1'b0, 8'hFF, 8, 1, 1'b0, 1'b0, 16, -1, -1);
    model_event(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (act_vec() !== exp_vec()) begin
      n_err++; $display("FAIL frame_err_ff: got %h want %h", act_vec(), exp_vec());
    end
    do_read(1'b0);
    model_event(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    send_frame(1'b0, 8'h01, 8, 1, 1'b1, 1'b1, 0, -1, -1);
    model_event(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (act_vec() !== exp_vec()) begin
      n_err++; $display("FAIL frame_err_recover: got %h want %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_glitch();
    do_read(1'b0);
    model_event(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    busy_seen = 1'b0;
    ia.rx_in = 1'b0;
    repeat (3) begin @(posedge clk); #1; busy_seen |= ia.busy; end
    ia.rx_in = 1'b1;
    repeat (24) begin @(posedge clk); #1; busy_seen |= ia.busy; end
    n_cmp++;
    if (busy_seen !== 1'b1) begin
      n_err++; $display("FAIL glitch_busy_pulse: got %0b want 1", busy_seen);
    end
    n_cmp++;
    if (act_vec() !== exp_vec()) begin
      n_err++; $display("FAIL glitch_rejected: got %h want %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_back_to_back();
    send_frame(1'b0, 8'h11, 8, 1, ^8'h11, 1'b1, 0, -1, -1);
    model_event(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    send_frame(1'b0, 8'h22, 8, 1, ^8'h22, 1'b1, 0, -1, -1);
    model_event(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (act_vec() !== exp_vec()) begin
      n_err++; $display("FAIL b2b_overrun: got %h want %h", act_vec(), exp_vec());
    end
    do_read(1'b0);
    model_event(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (act_vec() !== exp_vec()) begin
      n_err++; $display("FAIL b2b_read_clear: got %h want %h", act_vec(), exp_vec());
    end
    send_frame(1'b0, 8'h11, 8, 1, ^8'h11, 1'b1, 0, -1, -1);
    model_event(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    send_frame(1'b0, 8'h22, 8, 1, ^8'h22, 1'b1, 0, commit_cyc(8, 1), -1);
    model_event(1'b1, 8'h22, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (act_vec() !== exp_vec()) begin
      n_err++; $display("FAIL b2b_read_on_commit: got %h want %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_mid();
    do_read(1'b0);
    model_event(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    send_frame(1'b0, 8'h5A, 8, 1, ^8'h5A, 1'b1, 0, -1, 85);
    model_reset();
    n_cmp++;
    if (rst_snap !== 13'h0) begin
      n_err++; $display("FAIL rst_mid_outputs: got %h want %h", rst_snap, 13'h0);
    end
    repeat (200) @(posedge clk);
    #1;
    n_cmp++;
    if (act_vec() !== exp_vec()) begin
      n_err++; $display("FAIL rst_mid_no_commit: got %h want %h", act_vec(), exp_vec());
    end
    send_frame(1'b0, 8'h5A, 8, 1, ^8'h5A, 1'b1, 0, -1, -1);
    model_event(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (act_vec() !== exp_vec()) begin
      n_err++; $display("FAIL rst_mid_clean_5a: got %h want %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    bit         bad_par;
    bit         stop_ok;
    bit         rd_commit;
    int         gap;
    for (int i = 0; i < 14; i++) begin
      d         = 8'($urandom);
      bad_par   = ($urandom_range(3, 0) == 0);
      stop_ok   = ($urandom_range(5, 0) != 0);
      rd_commit = ($urandom_range(3, 0) == 0);
      gap       = stop_ok ? int'($urandom_range(3, 0)) * 4 : 16;
      send_frame(1'b0, d, 8, 1, (^d) ^ bad_par, stop_ok, gap,
                 rd_commit ? commit_cyc(8, 1) : -1, -1);
      model_event(1'b1, d, bad_par, !stop_ok, rd_commit);
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_err++; $display("FAIL random_frame_%0d: got %h want %h", i, act_vec(), exp_vec());
      end
      if ($urandom_range(1, 0) == 1) begin
        do_read(1'b0);
        model_event(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (act_vec() !== exp_vec()) begin
          n_err++; $display("FAIL random_read_%0d: got %h want %h", i, act_vec(), exp_vec());
        end
      end
    end
  endtask

  task automatic test_no_parity();
    logic [6:0] d7;
    d7 = 7'($urandom);
    send_frame(1'b1, {1'b0, d7}, 7, 0, 1'b0, 1'b1, 0, -1, -1);
    n_cmp++;
    if (rise_edge != commit_cyc(7, 0)) begin
      n_err++; $display("FAIL nopar_latency: got edge %0d want %0d", rise_edge, commit_cyc(7, 0));
    end
    n_cmp++;
    if ({ib.rx_valid, ib.rx_data, ib.parity_err, ib.frame_err, ib.overrun_err} !== {1'b1, d7, 3'b000}) begin
      n_err++; $display("FAIL nopar_data: got %h want %h",
                        {ib.rx_valid, ib.rx_data, ib.parity_err, ib.frame_err, ib.overrun_err},
                        {1'b1, d7, 3'b000});
    end
    do_read(1'b1);
    send_frame(1'b1, 8'h2B, 7, 0, 1'b0, 1'b0, 16, -1, -1);
    n_cmp++;
    if ({ib.rx_valid, ib.rx_data, ib.parity_err, ib.frame_err, ib.overrun_err, ib.busy} !==
        {1'b1, 7'h2B, 4'b0100}) begin
      n_err++; $display("FAIL nopar_frame_err: got %h want %h",
                        {ib.rx_valid, ib.rx_data, ib.parity_err, ib.frame_err, ib.overrun_err, ib.busy},
                        {1'b1, 7'h2B, 4'b0100});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_frame_err();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_no_parity();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
